// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and drives every datapath control.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE  = 4'd1,  S_MEMADDR = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECUTE = 4'd6,  S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,  S_JUMP    = 4'd9,  S_ADDI_EX = 4'd10, S_LUI_EX  = 4'd11,
    S_IMM_WB   = 4'd12, S_TRAP    = 4'd13
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_fetch, r_jump_pc, r_pc_write_cond, r_iord, r_mem_read, r_mem_write;
  logic       r_mem_to_reg, r_reg_write, r_reg_dst, r_alu_src_a, r_illegal;
  logic [1:0] r_alu_src_b, r_pc_source, r_alu_op;
  logic       w_fetch, w_jump_pc, w_pc_write_cond, w_iord, w_mem_read, w_mem_write;
  logic       w_mem_to_reg, w_reg_write, w_reg_dst, w_alu_src_a, w_illegal;
  logic [1:0] w_alu_src_b, w_pc_source, w_alu_op;

  // mem_ready is a completion strobe: in FETCH, MEMREAD and MEMWRITE the access
  // is held (state and controls unchanged) until the cycle mem_ready is high.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          6'h00:        w_next = S_EXECUTE;
          6'h23, 6'h2B: w_next = S_MEMADDR;
          6'h04:        w_next = S_BRANCH;
          6'h02:        w_next = S_JUMP;
          6'h08:        w_next = S_ADDI_EX;
          6'h0F:        w_next = S_LUI_EX;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADDR:  w_next = (opcode == 6'h23) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  w_next = S_RTYPE_WB;
      S_ADDI_EX:  w_next = S_IMM_WB;
      S_LUI_EX:   w_next = S_IMM_WB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Controls are decoded from the next state so they register alongside it.
  always_comb begin
    w_fetch = 1'b0;  w_jump_pc = 1'b0;  w_pc_write_cond = 1'b0;  w_iord = 1'b0;
    w_mem_read = 1'b0;  w_mem_write = 1'b0;  w_mem_to_reg = 1'b0;  w_reg_write = 1'b0;
    w_reg_dst = 1'b0;  w_alu_src_a = 1'b0;  w_illegal = 1'b0;
    w_alu_src_b = 2'b00;  w_pc_source = 2'b00;  w_alu_op = 2'b00;
    case (w_next)
      S_FETCH:    begin w_fetch = 1'b1; w_mem_read = 1'b1; w_alu_src_b = 2'b01; end
      S_DECODE:   w_alu_src_b = 2'b11;
      S_MEMADDR:  begin w_alu_src_a = 1'b1; w_alu_src_b = 2'b10; end
      S_MEMREAD:  begin w_mem_read = 1'b1; w_iord = 1'b1; end
      S_MEMWB:    begin w_reg_write = 1'b1; w_mem_to_reg = 1'b1; end
      S_MEMWRITE: begin w_mem_write = 1'b1; w_iord = 1'b1; end
      S_EXECUTE:  begin w_alu_src_a = 1'b1; w_alu_op = 2'b10; end
      S_RTYPE_WB: begin w_reg_dst = 1'b1; w_reg_write = 1'b1; end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;  w_alu_op = 2'b01;
        w_pc_write_cond = 1'b1;  w_pc_source = 2'b01;
      end
      S_JUMP:     begin w_jump_pc = 1'b1; w_pc_source = 2'b10; end
      S_ADDI_EX:  begin w_alu_src_a = 1'b1; w_alu_src_b = 2'b10; end
      S_LUI_EX:   begin w_alu_src_a = 1'b1; w_alu_src_b = 2'b10; w_alu_op = 2'b11; end
      S_IMM_WB:   w_reg_write = 1'b1;
      S_TRAP:     w_illegal = 1'b1;
      default:    w_illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_fetch <= 1'b1;  r_jump_pc <= 1'b0;  r_pc_write_cond <= 1'b0;  r_iord <= 1'b0;
      r_mem_read <= 1'b1;  r_mem_write <= 1'b0;  r_mem_to_reg <= 1'b0;
      r_reg_write <= 1'b0;  r_reg_dst <= 1'b0;  r_alu_src_a <= 1'b0;  r_illegal <= 1'b0;
      r_alu_src_b <= 2'b01;  r_pc_source <= 2'b00;  r_alu_op <= 2'b00;
    end else begin
      r_state <= w_next;
      r_fetch <= w_fetch;  r_jump_pc <= w_jump_pc;  r_pc_write_cond <= w_pc_write_cond;
      r_iord <= w_iord;  r_mem_read <= w_mem_read;  r_mem_write <= w_mem_write;
      r_mem_to_reg <= w_mem_to_reg;  r_reg_write <= w_reg_write;  r_reg_dst <= w_reg_dst;
      r_alu_src_a <= w_alu_src_a;  r_illegal <= w_illegal;
      r_alu_src_b <= w_alu_src_b;  r_pc_source <= w_pc_source;  r_alu_op <= w_alu_op;
    end
  end

  // Fetch-time enables follow mem_ready live; rst_n gates them so reset forces 0.
  assign IRWrite     = r_fetch & mem_ready & rst_n;
  assign PCWrite     = r_jump_pc | (r_fetch & mem_ready & rst_n);
  assign PCWriteCond = r_pc_write_cond;
  assign IorD        = r_iord;
  assign MemRead     = r_mem_read;
  assign MemWrite    = r_mem_write;
  assign MemtoReg    = r_mem_to_reg;
  assign RegWrite    = r_reg_write;
  assign RegDst      = r_reg_dst;
  assign ALUSrcA     = r_alu_src_a;
  assign ALUSrcB     = r_alu_src_b;
  assign PCSource    = r_pc_source;
  assign ALUOp       = r_alu_op;
  assign state       = r_state;
  assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-cycle expected control
// vectors are queued as stimulus is driven and compared against the outputs.
module tb_mips_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state;

  mips_multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .state(state), .illegal_op(illegal_op)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  localparam int W = 21;
  logic [W-1:0] exp_q[$];
  logic [3:0]   seq_st[$];
  logic         seq_mr[$];
  logic [5:0]   seq_op[$];
  int n_checks = 0;
  int n_pass   = 0;

  wire [W-1:0] obs = {state, illegal_op, PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                      MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp};

  // Expected outputs for a state, straight from the per-state control table.
  function automatic logic [W-1:0] model(input logic [3:0] st, input logic mr);
    logic il, pw, pwc, iord, mrd, mwr, m2r, irw, rw, rd, asa;
    logic [1:0] asb, psrc, aop;
    {il, pw, pwc, iord, mrd, mwr, m2r, irw, rw, rd, asa} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  begin mrd = 1'b1; iord = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mwr = 1'b1; iord = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
      4'd9:  begin pw = 1'b1; psrc = 2'b10; end
      4'd10: begin asa = 1'b1; asb = 2'b10; end
      4'd11: begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
      4'd12: rw = 1'b1;
      4'd13: il = 1'b1;
      default: il = 1'b0;
    endcase
    return {st, il, pw, pwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, asb, psrc, aop};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic add_step(input logic [3:0] st, input logic mr, input logic [5:0] op);
    seq_st.push_back(st);
    seq_mr.push_back(mr);
    seq_op.push_back(op);
  endtask

  // Expected per-cycle state trace of one instruction; mem_ready is random
  // wherever it must be ignored.
  task automatic add_instr(input logic [5:0] op, input int sf, input int sm);
    repeat (sf) add_step(4'd0, 1'b0, op);
    add_step(4'd0, 1'b1, op);
    add_step(4'd1, 1'($urandom_range(0, 1)), op);
    case (op)
      6'h00: begin add_step(4'd6, 1'($urandom_range(0, 1)), op);
                   add_step(4'd7, 1'($urandom_range(0, 1)), op); end
      6'h23: begin add_step(4'd2, 1'($urandom_range(0, 1)), op);
                   repeat (sm) add_step(4'd3, 1'b0, op);
                   add_step(4'd3, 1'b1, op);
                   add_step(4'd4, 1'($urandom_range(0, 1)), op); end
      6'h2B: begin add_step(4'd2, 1'($urandom_range(0, 1)), op);
                   repeat (sm) add_step(4'd5, 1'b0, op);
                   add_step(4'd5, 1'b1, op); end
      6'h04: add_step(4'd8, 1'($urandom_range(0, 1)), op);
      6'h02: add_step(4'd9, 1'($urandom_range(0, 1)), op);
      6'h08: begin add_step(4'd10, 1'($urandom_range(0, 1)), op);
                   add_step(4'd12, 1'($urandom_range(0, 1)), op); end
      6'h0F: begin add_step(4'd11, 1'($urandom_range(0, 1)), op);
                   add_step(4'd12, 1'($urandom_range(0, 1)), op); end
      default: repeat (sm) add_step(4'd13, 1'($urandom_range(0, 1)), op);
    endcase
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [W-1:0] got, exp_v;
    logic [3:0] after_st[4];
    after_st = '{4'd1, 4'd6, 4'd7, 4'd0};
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(model(4'd0, 1'b0));
    got = obs; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL reset_hold: got %h expected %h", got, exp_v);
    else n_pass++;
    #2 rst_n = 1'b1;
    #1;
    exp_q.push_back(model(4'd0, 1'b1));
    got = obs; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL reset_release_fetch: got %h expected %h", got, exp_v);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 2) mem_ready = 1'b0;
      exp_q.push_back(model(after_st[i], mem_ready));
      got = obs; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL reset_after_%0d: got %h expected %h", i, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_rtype;
    logic [W-1:0] got, exp_v;
    add_instr(6'h00, 0, 0);
    add_step(4'd0, 1'b0, 6'h00);
    for (int i = 0; seq_st.size() > 0; i++) begin
      opcode = seq_op.pop_front(); mem_ready = seq_mr.pop_front();
      exp_q.push_back(model(seq_st.pop_front(), mem_ready));
      @(negedge clk);
      got = obs; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL rtype step %0d: got %h expected %h", i, got, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_stall;
    logic [W-1:0] got, exp_v;
    add_instr(6'h23, 1, 2);
    add_step(4'd0, 1'b0, 6'h23);
    for (int i = 0; seq_st.size() > 0; i++) begin
      opcode = seq_op.pop_front(); mem_ready = seq_mr.pop_front();
      exp_q.push_back(model(seq_st.pop_front(), mem_ready));
      @(negedge clk);
      got = obs; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL lw_stall step %0d: got %h expected %h", i, got, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_branch_jump;
    logic [W-1:0] got, exp_v;
    add_instr(6'h2B, 0, 1);
    add_instr(6'h04, 0, 0);
    add_instr(6'h02, 0, 0);
    add_step(4'd0, 1'b0, 6'h02);
    for (int i = 0; seq_st.size() > 0; i++) begin
      opcode = seq_op.pop_front(); mem_ready = seq_mr.pop_front();
      exp_q.push_back(model(seq_st.pop_front(), mem_ready));
      @(negedge clk);
      got = obs; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL sw_beq_j step %0d: got %h expected %h", i, got, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_immediates;
    logic [W-1:0] got, exp_v;
    add_instr(6'h0F, 0, 0);
    add_instr(6'h08, 0, 0);
    add_step(4'd0, 1'b0, 6'h08);
    for (int i = 0; seq_st.size() > 0; i++) begin
      opcode = seq_op.pop_front(); mem_ready = seq_mr.pop_front();
      exp_q.push_back(model(seq_st.pop_front(), mem_ready));
      @(negedge clk);
      got = obs; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL imm step %0d: got %h expected %h", i, got, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] got, exp_v;
    logic [5:0] legal_ops[7];
    legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0F};
    for (int k = 0; k < 12; k++)
      add_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2));
    add_step(4'd0, 1'b0, 6'h00);
    for (int i = 0; seq_st.size() > 0; i++) begin
      opcode = seq_op.pop_front(); mem_ready = seq_mr.pop_front();
      exp_q.push_back(model(seq_st.pop_front(), mem_ready));
      @(negedge clk);
      got = obs; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL b2b step %0d: got %h expected %h", i, got, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write;
    logic [W-1:0] got, exp_v;
    add_step(4'd0, 1'b1, 6'h2B);
    add_step(4'd1, 1'b1, 6'h2B);
    add_step(4'd2, 1'b1, 6'h2B);
    add_step(4'd5, 1'b0, 6'h2B);
    for (int i = 0; seq_st.size() > 0; i++) begin
      opcode = seq_op.pop_front(); mem_ready = seq_mr.pop_front();
      exp_q.push_back(model(seq_st.pop_front(), mem_ready));
      @(negedge clk);
      got = obs; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL sw_hold step %0d: got %h expected %h", i, got, exp_v);
      else n_pass++;
      @(posedge clk); #1;
    end
    #1;
    exp_q.push_back(model(4'd5, 1'b0));
    got = obs; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL sw_still_held: got %h expected %h", got, exp_v);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(model(4'd0, 1'b0));
    got = obs; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL async_reset_drops_write: got %h expected %h", got, exp_v);
    else n_pass++;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(4'd0, 1'b0));
    got = obs; exp_v = exp_q.pop_front(); n_checks++;
    if (got !== exp_v) $display("FAIL post_reset_fetch: got %h expected %h", got, exp_v);
    else n_pass++;
  endtask

  task automatic test_illegal;
    logic [W-1:0] got, exp_v;
    logic [5:0] bad_ops[5];
    bad_ops = '{6'h01, 6'h05, 6'h22, 6'h2A, 6'h3E};
    for (int r = 0; r < 2; r++) begin
      add_instr((r == 0) ? 6'h3F : bad_ops[$urandom_range(0, 4)], 0, 12);
      for (int i = 0; seq_st.size() > 0; i++) begin
        opcode = seq_op.pop_front(); mem_ready = seq_mr.pop_front();
        exp_q.push_back(model(seq_st.pop_front(), mem_ready));
        @(negedge clk);
        got = obs; exp_v = exp_q.pop_front(); n_checks++;
        if (got !== exp_v) $display("FAIL trap%0d step %0d: got %h expected %h", r, i, got, exp_v);
        else n_pass++;
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(model(4'd0, 1'b0));
      got = obs; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL trap%0d_reset: got %h expected %h", r, got, exp_v);
      else n_pass++;
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(model(4'd0, 1'b0));
      got = obs; exp_v = exp_q.pop_front(); n_checks++;
      if (got !== exp_v) $display("FAIL trap%0d_exit: got %h expected %h", r, got, exp_v);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'h00;
    test_reset();
    test_rtype();
    test_load_stall();
    test_store_branch_jump();
    test_immediates();
    test_back_to_back();
    test_reset_mid_write();
    test_illegal();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
